priority_encoder_iter: RTL and testbench

Parametrised, handshaked priority encoder: the next generation of the team's fixed 4-to-2 encoder. It captures an N-bit request vector and emits the index of every set bit, one per beat, highest index first, with a last-beat marker and an explicit "no bits set" flag. It sits between request sources and any consumer that must service each asserted line in turn, such as interrupt or event dispatch.

---
 rtl/priority_encoder_pkg.sv | 28 ++
 rtl/priority_encoder_iter_find.sv | 25 ++
 rtl/priority_encoder_iter.sv | 100 ++++++++++
 tb/tb_priority_encoder_iter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared types and bit-scan helpers for the iterative priority encoder.
package priority_encoder_pkg;

  // Helpers operate on a widened vector; callers zero-extend into it.
  localparam int PENC_MAX_N = 64;

  typedef enum logic {
    PENC_IDLE,
    PENC_SCAN
  } penc_state_e;

  function automatic int penc_hi_idx(input logic [PENC_MAX_N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < PENC_MAX_N; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  function automatic int penc_popcount(input logic [PENC_MAX_N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < PENC_MAX_N; i++)
      r = r + int'(v[i]);
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_iter_find.sv
// Combinational highest-set-bit finder with any/multi flags.
module priority_find
  import priority_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic [PENC_MAX_N-1:0] ext;

  always_comb begin
    ext        = '0;
    ext[N-1:0] = vec;
    idx        = W'(penc_hi_idx(ext));
    any        = |vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi      = |(vec & (vec - N'(1)));
  end

endmodule

// File: rtl/priority_encoder_iter.sv
// Iterative priority encoder: captures a vector, emits set indices high-to-low.
// Optional popcount output out_cnt enabled by defining PENC_COUNT_EN.
module priority_encoder_iter
  import priority_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
`ifdef PENC_COUNT_EN
  ,output logic [W:0]  out_cnt
`endif
);

  penc_state_e  state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] f_idx;
  logic         f_any, f_multi;

  priority_find #(.N(N)) u_find (
    .vec   (pend_q),
    .idx   (f_idx),
    .any   (f_any),
    .multi (f_multi)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    case (state_q)
      PENC_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pend_d  = in_vec;
          state_d = PENC_SCAN;
        end
      end
      PENC_SCAN: begin
        out_valid = 1'b1;
        out_idx   = f_idx;
        out_last  = ~f_multi;
        out_none  = ~f_any;
        if (out_ready) begin
          if (!f_multi) begin
            pend_d  = '0;
            state_d = PENC_IDLE;
          end else begin
            pend_d = pend_q & ~(N'(1) << f_idx);
          end
        end
      end
      default: state_d = PENC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PENC_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PENC_COUNT_EN
  logic [W:0]            cnt_q;
  logic [PENC_MAX_N-1:0] in_ext;

  always_comb begin
    in_ext        = '0;
    in_ext[N-1:0] = in_vec;
  end

  // Captured alongside pending so it stays constant for the whole burst.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q == PENC_IDLE && in_valid)
      cnt_q <= (W+1)'(penc_popcount(in_ext));
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_priority_encoder_iter.sv
// Self-checking bench: N=4 and N=8 encoders against a queue-based beat model.
module tb_priority_encoder_iter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv;
  logic [7:0] vec;
  logic       ordy;
  int         dsel;

  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_last, a_none;
  logic [3:0] a_vec;
  logic [1:0] a_idx;
  logic       b_iv, b_ir, b_ov, b_last, b_none;
  logic [7:0] b_vec;
  logic [2:0] b_idx;
`ifdef PENC_COUNT_EN
  logic [2:0] a_cnt;
  logic [3:0] b_cnt;
`endif

  assign a_iv  = iv & (dsel == 0);
  assign b_iv  = iv & (dsel == 1);
  assign a_vec = vec[3:0];
  assign b_vec = vec;

  priority_encoder_iter #(.N(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_vec(a_vec),
    .out_valid(a_ov), .out_ready(ordy), .out_idx(a_idx), .out_last(a_last),
    .out_none(a_none)
`ifdef PENC_COUNT_EN
    , .out_cnt(a_cnt)
`endif
  );

  priority_encoder_iter #(.N(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_vec(b_vec),
    .out_valid(b_ov), .out_ready(ordy), .out_idx(b_idx), .out_last(b_last),
    .out_none(b_none)
`ifdef PENC_COUNT_EN
    , .out_cnt(b_cnt)
`endif
  );

  logic       s_ir, s_ov, s_last, s_none;
  logic [2:0] s_idx;
  logic [3:0] s_cnt;

  always_comb begin
    if (dsel == 0) begin
      s_ir = a_ir; s_ov = a_ov; s_last = a_last; s_none = a_none; s_idx = {1'b0, a_idx};
    end else begin
      s_ir = b_ir; s_ov = b_ov; s_last = b_last; s_none = b_none; s_idx = b_idx;
    end
    s_cnt = '0;
`ifdef PENC_COUNT_EN
    s_cnt = (dsel == 0) ? {1'b0, a_cnt} : b_cnt;
`endif
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: beats are the set indices in descending order, or one "none" beat.
  task automatic send(input int sel, input logic [7:0] v, input int stall0, input bit rnd);
    int q[$];
    int pc, nb, to, w;
    dsel = sel;
    w = (sel == 0) ? 4 : 8;
    q = {};
    for (int i = w - 1; i >= 0; i--)
      if (v[i]) q.push_back(i);
    pc = q.size();
    nb = (pc == 0) ? 1 : pc;
    to = 0;
    while (s_ir !== 1'b1 && to < 50) begin
      tick;
      to++;
    end
    n_vec++;
    if (s_ir !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: in_ready=%b required 1", s_ir);
    end
    iv = 1'b1; vec = v; ordy = 1'b0;
    tick;
    iv = 1'b0;
    for (int b = 0; b < nb; b++) begin
      int  e_idx;
      bit  e_last, e_none;
      int  st;
      e_idx  = (pc == 0) ? 0 : q[b];
      e_last = (b == nb - 1);
      e_none = (pc == 0);
      st     = (b == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= st; s++) begin
        ordy = (s == st);
        n_vec++;
        if (s_ov !== 1'b1 || s_ir !== 1'b0 || s_idx !== e_idx[2:0] ||
            s_last !== e_last || s_none !== e_none) begin
          n_err++;
          $display("FAIL beat vec=%h b=%0d: v/r/idx/last/none=%b/%b/%0d/%b/%b required 1/0/%0d/%b/%b",
                   v, b, s_ov, s_ir, s_idx, s_last, s_none, e_idx, e_last, e_none);
        end
`ifdef PENC_COUNT_EN
        n_vec++;
        if (s_cnt !== pc[3:0]) begin
          n_err++;
          $display("FAIL cnt vec=%h: out_cnt=%0d required %0d", v, s_cnt, pc);
        end
`endif
        tick;
      end
    end
    ordy = 1'b0;
    n_vec++;
    if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
      n_err++;
      $display("FAIL post_burst vec=%h: out_valid=%b in_ready=%b required 0/1", v, s_ov, s_ir);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iv = 1'b1; vec = 8'hA5; ordy = 1'b0; dsel = 0;
    tick; tick;
    n_vec++;
    if (a_ir !== 1'b1 || a_ov !== 1'b0 || a_idx !== 2'd0 || a_last !== 1'b0 || a_none !== 1'b0) begin
      n_err++;
      $display("FAIL reset_n4: r/v/idx/last/none=%b/%b/%0d/%b/%b required 1/0/0/0/0",
               a_ir, a_ov, a_idx, a_last, a_none);
    end
    n_vec++;
    if (b_ir !== 1'b1 || b_ov !== 1'b0 || b_idx !== 3'd0 || b_last !== 1'b0 || b_none !== 1'b0) begin
      n_err++;
      $display("FAIL reset_n8: r/v/idx/last/none=%b/%b/%0d/%b/%b required 1/0/0/0/0",
               b_ir, b_ov, b_idx, b_last, b_none);
    end
`ifdef PENC_COUNT_EN
    n_vec++;
    if (a_cnt !== 3'd0 || b_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_cnt: %0d/%0d required 0/0", a_cnt, b_cnt);
    end
`endif
    iv = 1'b0; vec = '0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fixed;
    send(0, 8'h00, 0, 0);
    send(0, 8'h07, 0, 0);
    send(1, 8'h81, 3, 0);
    send(1, 8'h80, 0, 0);
    send(1, 8'h01, 0, 0);
  endtask

  task automatic test_held;
    int exp_idx[6];
    bit exp_last[6];
    exp_idx  = '{3, 1, 3, 2, 1, 0};
    exp_last = '{0, 1, 0, 0, 0, 1};
    dsel = 0; ordy = 1'b1; iv = 1'b1; vec = 8'h0A;
    tick;
    vec = 8'h0F;
    for (int b = 0; b < 6; b++) begin
      if (b == 2) begin
        n_vec++;
        if (s_ir !== 1'b1 || s_ov !== 1'b0) begin
          n_err++;
          $display("FAIL held_gap: in_ready=%b out_valid=%b required 1/0", s_ir, s_ov);
        end
        tick;
      end
      n_vec++;
      if (s_ov !== 1'b1 || s_ir !== 1'b0 || s_idx !== exp_idx[b][2:0] || s_last !== exp_last[b]) begin
        n_err++;
        $display("FAIL held_beat %0d: v/r/idx/last=%b/%b/%0d/%b required 1/0/%0d/%b",
                 b, s_ov, s_ir, s_idx, s_last, exp_idx[b], exp_last[b]);
      end
      if (b == 5) iv = 1'b0;
      tick;
    end
    ordy = 1'b0;
    n_vec++;
    if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
      n_err++;
      $display("FAIL held_end: out_valid=%b in_ready=%b required 0/1", s_ov, s_ir);
    end
  endtask

  task automatic test_reset_mid;
    dsel = 1; ordy = 1'b1; iv = 1'b1; vec = 8'hFF;
    tick;
    iv = 1'b0;
    n_vec++;
    if (s_idx !== 3'd7 || s_ov !== 1'b1) begin
      n_err++;
      $display("FAIL mid_beat0: idx=%0d valid=%b required 7/1", s_idx, s_ov);
    end
    tick;
    n_vec++;
    if (s_idx !== 3'd6 || s_ov !== 1'b1) begin
      n_err++;
      $display("FAIL mid_beat1: idx=%0d valid=%b required 6/1", s_idx, s_ov);
    end
    rst_n = 1'b0; iv = 1'b1; vec = 8'h55;
    tick;
    n_vec++;
    if (s_ov !== 1'b0 || s_ir !== 1'b1 || s_idx !== 3'd0 || s_last !== 1'b0 || s_none !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: v/r/idx/last/none=%b/%b/%0d/%b/%b required 0/1/0/0/0",
               s_ov, s_ir, s_idx, s_last, s_none);
    end
    rst_n = 1'b1; iv = 1'b0; ordy = 1'b0;
    tick;
    n_vec++;
    if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ignore: out_valid=%b in_ready=%b required 0/1", s_ov, s_ir);
    end
    send(1, 8'h10, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int         sel;
      logic [7:0] v;
      sel = int'($urandom_range(0, 1));
      v   = 8'($urandom);
      case ($urandom_range(0, 5))
        0: v = 8'h00;
        1: v = 8'(1) << $urandom_range(0, 7);
        default: ;
      endcase
      if (sel == 0) v[7:4] = 4'h0;
      send(sel, v, int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fixed;
    test_held;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
